// File: rtl/dds_wave_gen.sv
// dds_wave_gen: DDS tone generator with sine/square/triangle/sawtooth output.
// Phase accumulator plus gate FSM. Notes stop only on a full-cycle boundary.
// A two-stage pipeline maps the phase index to a 10-bit offset-binary sample.
module dds_wave_gen #(
    parameter int              PHASE_W     = 32,
    parameter longint unsigned DEFAULT_FTW = 64'd93664
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic               ftw_valid,
    output logic               ftw_ready,
    input  logic [1:0]         wave_sel,
    input  logic               gate,
    input  logic               phase_sync,
    output logic [9:0]         wave_out,
    output logic               wave_valid,
    output logic               active
);
    localparam int                 STAGES  = 2;
    localparam logic [PHASE_W-1:0] FTW_RST = PHASE_W'(DEFAULT_FTW);
    localparam logic [9:0]         MID     = 10'd511;
    localparam logic [1:0]         M_SINE  = 2'b00;
    localparam logic [1:0]         M_SQR   = 2'b01;
    localparam logic [1:0]         M_TRI   = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] cur_ftw;
    logic [PHASE_W-1:0] pend_ftw;
    logic               pend;
    logic [1:0]         mode;

    logic [PHASE_W:0]   sum;
    logic               carry;
    logic               running;
    logic               boundary;
    logic               ftw_take;
    logic               run_nxt;

    // vld_pipe[0] is the registered "generator live" flag. Each higher bit
    // tracks that flag down the sample pipeline.
    logic [STAGES:0]    vld_pipe;

    logic [7:0]         p_s1;
    logic [1:0]         mode_s1;
    logic [5:0]         addr;
    logic [9:0]         tval;
    logic [9:0]         sample;

    // A boundary is either a natural wrap of the accumulator or a forced restart.
    assign sum      = {1'b0, acc} + {1'b0, cur_ftw};
    assign carry    = sum[PHASE_W];
    assign running  = (state != IDLE);
    assign boundary = running && (carry || phase_sync);

    // A pending word is applied at once when nothing is playing or the
    // current word is stalled at zero. Otherwise it waits for the cycle edge
    // so the pitch change stays phase continuous.
    assign ftw_take  = pend && (boundary || !running || (cur_ftw == '0));
    assign ftw_ready = !pend;

    // Next-cycle liveness. It lets active switch on the same edge as the state.
    assign run_nxt    = (state == IDLE) ? gate : !((state == RELEASE) && boundary);
    assign active     = vld_pipe[0];
    assign wave_valid = vld_pipe[STAGES];

    // Quarter-wave sine table: floor(512*sin(pi*k/128)), clipped to 511.
    function automatic logic [8:0] sin_q(input logic [5:0] a);
        sin_q = '0;
        case (a)
            6'd0:  sin_q = 9'd0;   6'd1:  sin_q = 9'd12;  6'd2:  sin_q = 9'd25;  6'd3:  sin_q = 9'd37;
            6'd4:  sin_q = 9'd50;  6'd5:  sin_q = 9'd62;  6'd6:  sin_q = 9'd75;  6'd7:  sin_q = 9'd87;
            6'd8:  sin_q = 9'd99;  6'd9:  sin_q = 9'd112; 6'd10: sin_q = 9'd124; 6'd11: sin_q = 9'd136;
            6'd12: sin_q = 9'd148; 6'd13: sin_q = 9'd160; 6'd14: sin_q = 9'd172; 6'd15: sin_q = 9'd184;
            6'd16: sin_q = 9'd195; 6'd17: sin_q = 9'd207; 6'd18: sin_q = 9'd218; 6'd19: sin_q = 9'd230;
            6'd20: sin_q = 9'd241; 6'd21: sin_q = 9'd252; 6'd22: sin_q = 9'd263; 6'd23: sin_q = 9'd273;
            6'd24: sin_q = 9'd284; 6'd25: sin_q = 9'd294; 6'd26: sin_q = 9'd304; 6'd27: sin_q = 9'd314;
            6'd28: sin_q = 9'd324; 6'd29: sin_q = 9'd334; 6'd30: sin_q = 9'd343; 6'd31: sin_q = 9'd353;
            6'd32: sin_q = 9'd362; 6'd33: sin_q = 9'd370; 6'd34: sin_q = 9'd379; 6'd35: sin_q = 9'd387;
            6'd36: sin_q = 9'd395; 6'd37: sin_q = 9'd403; 6'd38: sin_q = 9'd411; 6'd39: sin_q = 9'd418;
            6'd40: sin_q = 9'd425; 6'd41: sin_q = 9'd432; 6'd42: sin_q = 9'd439; 6'd43: sin_q = 9'd445;
            6'd44: sin_q = 9'd451; 6'd45: sin_q = 9'd457; 6'd46: sin_q = 9'd462; 6'd47: sin_q = 9'd468;
            6'd48: sin_q = 9'd473; 6'd49: sin_q = 9'd477; 6'd50: sin_q = 9'd482; 6'd51: sin_q = 9'd486;
            6'd52: sin_q = 9'd489; 6'd53: sin_q = 9'd493; 6'd54: sin_q = 9'd496; 6'd55: sin_q = 9'd499;
            6'd56: sin_q = 9'd502; 6'd57: sin_q = 9'd504; 6'd58: sin_q = 9'd506; 6'd59: sin_q = 9'd508;
            6'd60: sin_q = 9'd509; 6'd61: sin_q = 9'd510; 6'd62: sin_q = 9'd511; 6'd63: sin_q = 9'd511;
            default: sin_q = 9'd0;
        endcase
    endfunction

    // Gate FSM and phase accumulator. A release only ends on a boundary.
    // A forced restart takes priority over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    acc <= '0;
                    if (gate) state <= RUN;
                end
                RUN: begin
                    acc <= phase_sync ? '0 : sum[PHASE_W-1:0];
                    if (!gate) state <= RELEASE;
                end
                RELEASE: begin
                    if (boundary) begin
                        acc   <= '0;
                        state <= IDLE;
                    end else begin
                        acc <= sum[PHASE_W-1:0];
                        if (gate) state <= RUN;
                    end
                end
                default: begin
                    acc   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tuning-word handshake: a one-deep holding register, drained at a safe point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ftw  <= FTW_RST;
            pend_ftw <= '0;
            pend     <= 1'b0;
        end else if (ftw_take) begin
            cur_ftw <= pend_ftw;
            pend    <= 1'b0;
        end else if (ftw_valid && !pend) begin
            pend_ftw <= ftw_in;
            pend     <= 1'b1;
        end
    end

    // The waveform mode only changes between cycles, so the shape never switches mid-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   mode <= M_SINE;
        else if (!running || boundary) mode <= wave_sel;
    end

    // Liveness shift register. Bit 0 is active, and the top bit is wave_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[STAGES-1:0], run_nxt};
    end

    // Stage 1: capture the phase index and mode for the current accumulator value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_s1    <= '0;
            mode_s1 <= M_SINE;
        end else begin
            p_s1    <= acc[PHASE_W-1 -: 8];
            mode_s1 <= mode;
        end
    end

    // Waveform shaping from the stage-1 phase index.
    always_comb begin
        addr   = p_s1[6] ? ~p_s1[5:0] : p_s1[5:0];
        tval   = {1'b0, sin_q(addr)};
        sample = MID;
        case (mode_s1)
            M_SINE:  sample = p_s1[7] ? (MID - tval) : (MID + tval);
            M_SQR:   sample = p_s1[7] ? 10'd0 : 10'd1022;
            M_TRI:   sample = p_s1[7] ? {~p_s1[6:0], 3'b000} : {p_s1[6:0], 3'b000};
            default: sample = {p_s1, 2'b00};
        endcase
    end

    // Stage 2: the output register. It parks at midscale when the sample came from an idle generator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           wave_out <= MID;
        else if (vld_pipe[1]) wave_out <= sample;
        else                  wave_out <= MID;
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: PHASE_W=12, default FTW 16 (256 clocks/period).
// Stimulus pushes one expected sample per live cycle; the monitor pops on wave_valid.
module tb_dds_wave_gen;
    localparam int PW  = 12;
    localparam int DEF = 16;
    localparam int MOD = 1 << PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [PW-1:0] ftw_in = '0;
    logic          ftw_valid = 1'b0;
    logic          ftw_ready;
    logic [1:0]    wave_sel = 2'b00;
    logic          gate = 1'b0;
    logic          phase_sync = 1'b0;
    logic [9:0]    wave_out;
    logic          wave_valid;
    logic          active;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int sin_t[64];

    // reference state: 0 idle, 1 run, 2 release
    int r_state, r_acc, r_ftw, r_pftw, r_mode;
    bit r_pend;

    always #5 clk = ~clk;

    dds_wave_gen #(.PHASE_W(PW), .DEFAULT_FTW(DEF)) dut (
        .clk(clk), .rst_n(rst_n), .ftw_in(ftw_in), .ftw_valid(ftw_valid),
        .ftw_ready(ftw_ready), .wave_sel(wave_sel), .gate(gate),
        .phase_sync(phase_sync), .wave_out(wave_out), .wave_valid(wave_valid),
        .active(active)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_wave(input int acc, input int mode);
        int p, k, t;
        p = (acc >> (PW - 8)) & 255;
        case (mode)
            0: begin
                k = p & 63;
                if ((p & 64) != 0) k = 63 - k;
                t = sin_t[k];
                return ((p & 128) != 0) ? 511 - t : 511 + t;
            end
            1:       return ((p & 128) != 0) ? 0 : 1022;
            2:       return ((p & 128) != 0) ? (127 - (p & 127)) * 8 : (p & 127) * 8;
            default: return p * 4;
        endcase
    endfunction

    task automatic ref_reset();
        r_state = 0; r_acc = 0; r_ftw = DEF; r_pftw = 0; r_mode = 0; r_pend = 0;
    endtask

    // One clock: queue the expected sample, advance the reference, step, check flags.
    task automatic cyc();
        int sum;
        bit run, carry, bnd;
        run = (r_state != 0);
        if (run) exp_q.push_back(exp_wave(r_acc, r_mode));
        sum   = r_acc + r_ftw;
        carry = (sum >= MOD);
        bnd   = run && (carry || phase_sync);
        if (r_pend && (bnd || !run || r_ftw == 0)) begin
            r_ftw = r_pftw; r_pend = 0;
        end else if (ftw_valid && !r_pend) begin
            r_pftw = int'(ftw_in); r_pend = 1;
        end
        if (bnd || !run) r_mode = int'(wave_sel);
        case (r_state)
            0: begin r_acc = 0; r_state = gate ? 1 : 0; end
            1: begin r_acc = phase_sync ? 0 : sum % MOD; r_state = gate ? 1 : 2; end
            default: begin
                if (bnd) begin r_acc = 0; r_state = 0; end
                else begin r_acc = sum % MOD; r_state = gate ? 1 : 2; end
            end
        endcase
        @(posedge clk);
        #1;
        ftw_valid  = 1'b0;
        phase_sync = 1'b0;
        check("active", int'(active), int'(r_state != 0));
        check("ftw_ready", int'(ftw_ready), int'(!r_pend));
    endtask

    task automatic load_ftw(input int w);
        ftw_in = PW'(w);
        ftw_valid = 1'b1;
        cyc();
    endtask

    task automatic run_to_acc(input int target);
        for (int i = 0; i < 2000; i++) begin
            if (r_acc == target) return;
            cyc();
        end
        check("run_to_acc_timeout", r_acc, target);
    endtask

    task automatic run_to_idle();
        for (int i = 0; i < 2000; i++) begin
            if (r_state == 0) return;
            cyc();
        end
        check("run_to_idle_timeout", r_state, 0);
    endtask

    // Monitor: each live sample must match the head of the queue; otherwise the output sits at midscale.
    always @(negedge clk) begin
        if (wave_valid === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_valid", int'(wave_valid), 0);
            else check("wave_out", int'(wave_out), exp_q.pop_front());
        end else begin
            check("idle_wave_out", int'(wave_out), 511);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 64; k++) begin
            real v;
            v = $floor(512.0 * $sin(3.14159265358979 * k / 128.0));
            if (v > 511.0) v = 511.0;
            sin_t[k] = int'(v);
        end
        ref_reset();

        // reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_wave_out", int'(wave_out), 511);
        check("rst_wave_valid", int'(wave_valid), 0);
        check("rst_ftw_ready", int'(ftw_ready), 1);
        check("rst_active", int'(active), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // sine at FTW 16: one full period and beyond
        wave_sel = 2'b00;
        gate = 1'b1;
        repeat (300) cyc();

        // load 32 mid-cycle; a second word while busy must be ignored
        load_ftw(32);
        load_ftw(64);
        repeat (400) cyc();

        // back to 16, then note-off at p=0x40 and release to idle
        load_ftw(16);
        repeat (300) cyc();
        run_to_acc('h400);
        gate = 1'b0;
        run_to_idle();
        repeat (5) cyc();

        // re-raise gate during release: no phase jump
        gate = 1'b1;
        repeat (3) cyc();
        run_to_acc('h400);
        gate = 1'b0;
        repeat (20) cyc();
        gate = 1'b1;
        repeat (300) cyc();

        // switch to triangle mid-cycle, then square
        wave_sel = 2'b10;
        repeat (400) cyc();
        wave_sel = 2'b01;
        repeat (300) cyc();

        // sawtooth with phase_sync restart
        wave_sel = 2'b11;
        repeat (300) cyc();
        run_to_acc('h900);
        phase_sync = 1'b1;
        cyc();
        repeat (20) cyc();

        // zero FTW freezes the phase; the next word applies at once
        load_ftw(0);
        repeat (300) cyc();
        load_ftw(48);
        repeat (200) cyc();

        // reset mid-note, load 32 first so the default word must come back
        load_ftw(32);
        repeat (300) cyc();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_wave_out", int'(wave_out), 511);
        check("midrst_wave_valid", int'(wave_valid), 0);
        check("midrst_ftw_ready", int'(ftw_ready), 1);
        check("midrst_active", int'(active), 0);
        exp_q.delete();
        ref_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (300) cyc();

        // drain
        gate = 1'b0;
        run_to_idle();
        repeat (5) cyc();
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
